// File: rtl/s_m_hist_pkg.sv
// Shared defaults and result-beat layout for the streaming histogram.
package s_m_hist_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned NUM_BINS_DEF    = 8;
    localparam int unsigned BIN_SHIFT_DEF   = 5;
    localparam int unsigned COUNT_WIDTH_DEF = 29;

    // Width of the bin index for a given bin count.
    function automatic int unsigned bin_idx_w(input int unsigned nb);
        return $clog2(nb);
    endfunction

    localparam int unsigned BIN_IDX_W = bin_idx_w(NUM_BINS_DEF);

    // Lowest bit of the bin field; the bin index sits in the top bits of the beat.
    function automatic int unsigned beat_bin_lsb(input int unsigned dw, input int unsigned nb);
        return dw - bin_idx_w(nb);
    endfunction

    // Result-beat field positions for the default build.
    localparam int unsigned BEAT_BIN_MSB = DATA_WIDTH_DEF - 1;
    localparam int unsigned BEAT_BIN_LSB = beat_bin_lsb(DATA_WIDTH_DEF, NUM_BINS_DEF);
    localparam int unsigned BEAT_CNT_MSB = COUNT_WIDTH_DEF - 1;
    localparam int unsigned BEAT_CNT_LSB = 0;

endpackage

// File: rtl/s_m_hist_bin_counter_bank.sv
// Bank of saturating per-bin counters; presents the post-increment value of the addressed bin.
module hist_bin_counter_bank
    import s_m_hist_pkg::*;
#(
    parameter int unsigned NUM_BINS    = NUM_BINS_DEF,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter int unsigned BIN_W       = bin_idx_w(NUM_BINS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [BIN_W-1:0]       i_bin,
    input  logic                   i_inc,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] r_cnt [NUM_BINS];
    logic [COUNT_WIDTH-1:0] w_cur;
    logic [COUNT_WIDTH-1:0] w_next;

    // Saturating increment of the addressed counter, read from the registered array.
    always_comb begin
        w_cur  = r_cnt[i_bin];
        w_next = (w_cur == '1) ? w_cur : w_cur + 1'b1;
    end

    assign o_count = w_next;

    // Counter storage; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_inc) begin
            r_cnt[i_bin] <= w_next;
        end
    end

endmodule

// File: rtl/s_m_hist.sv
// Streaming histogram: bins each accepted sample and emits {bin, updated count} one cycle later.
module s_m_hist
    import s_m_hist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned NUM_BINS    = NUM_BINS_DEF,
    parameter int unsigned BIN_SHIFT   = BIN_SHIFT_DEF,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned BIN_W   = bin_idx_w(NUM_BINS);
    localparam int unsigned BIN_LSB = beat_bin_lsb(DATA_WIDTH, NUM_BINS);

    logic                   r_run;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_over;
    logic [BIN_W-1:0]       w_bin;
    logic [COUNT_WIDTH-1:0] w_count;
    logic [DATA_WIDTH-1:0]  w_beat;

    // Reset release is registered so no sample is taken on the edge that sees deassertion.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_ready  = r_run & (~r_valid | m_axis_tready);
    assign w_accept = s_axis_tvalid & w_ready;

    // Bin selection: samples beyond the last bin's range clamp to the top bin.
    always_comb begin
        w_over = |(s_axis_tdata >> (BIN_SHIFT + BIN_W));
        w_bin  = w_over ? BIN_W'(NUM_BINS - 1) : s_axis_tdata[BIN_SHIFT +: BIN_W];
    end

    hist_bin_counter_bank #(
        .NUM_BINS    (NUM_BINS),
        .COUNT_WIDTH (COUNT_WIDTH),
        .BIN_W       (BIN_W)
    ) u_bank (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_bin   (w_bin),
        .i_inc   (w_accept),
        .o_count (w_count)
    );

    // Result beat: bin index in the top bits, count zero-extended from bit 0.
    always_comb begin
        w_beat                                  = '0;
        w_beat[BEAT_CNT_LSB +: COUNT_WIDTH]     = w_count;
        w_beat[BIN_LSB +: BIN_W]                = w_bin;
    end

    // Output slot: load on acceptance (replacing any beat being taken), drain when consumed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_beat;
        end else if (m_axis_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;

endmodule

// File: tb/tb_s_m_hist.sv
// Directed, table-driven bench for s_m_hist (default build plus a 3-bit-counter build).
module tb_s_m_hist;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    logic [31:0] s2_tdata;
    logic        s2_tvalid;
    logic        s2_tready;
    logic [31:0] m2_tdata;
    logic        m2_tvalid;
    logic        m2_tready;

    int unsigned n_pass;
    int unsigned n_total;

    typedef struct {
        bit          rst;
        logic [31:0] tdata;
        bit          tvalid;
        bit          mready;
        bit          exp_sready;
        bit          exp_mvalid;
        bit          chk_data;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t tbl[$];

    s_m_hist u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    s_m_hist #(
        .DATA_WIDTH  (32),
        .NUM_BINS    (8),
        .BIN_SHIFT   (5),
        .COUNT_WIDTH (3)
    ) u_dut_sat (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s2_tdata),
        .s_axis_tvalid (s2_tvalid),
        .s_axis_tready (s2_tready),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tready (m2_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse reset mid-cycle and return one edge after release, at posedge+1.
    task automatic do_reset();
        aresetn = 1'b0;
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic add(input bit rst, input logic [31:0] d, input bit v, input bit mr,
                       input bit esr, input bit emv, input bit cd, input logic [31:0] ed);
        vec_t t;
        t.rst = rst; t.tdata = d; t.tvalid = v; t.mready = mr;
        t.exp_sready = esr; t.exp_mvalid = emv; t.chk_data = cd; t.exp_mdata = ed;
        tbl.push_back(t);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        aresetn   = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        s2_tdata  = '0;
        s2_tvalid = 1'b0;
        m2_tready = 1'b0;

        // Back-to-back stream across bins, full throughput.
        add(1, 32'h10, 1, 1, 1, 1, 1, 32'h0000_0001);
        add(0, 32'h3F, 1, 1, 1, 1, 1, 32'h2000_0001);
        add(0, 32'h7F, 1, 1, 1, 1, 1, 32'h6000_0001);
        add(0, 32'hA5, 1, 1, 1, 1, 1, 32'hA000_0001);
        add(0, 32'hE0, 1, 1, 1, 1, 1, 32'hE000_0001);
        add(0, 32'hFF, 1, 1, 1, 1, 1, 32'hE000_0002);
        add(0, 32'hFF, 0, 1, 1, 0, 0, 32'h0);
        // Same bin back-to-back; an invalid cycle in between changes nothing.
        add(1, 32'h20, 1, 1, 1, 1, 1, 32'h2000_0001);
        add(0, 32'h20, 1, 1, 1, 1, 1, 32'h2000_0002);
        add(0, 32'h20, 1, 1, 1, 1, 1, 32'h2000_0003);
        add(0, 32'h20, 0, 1, 1, 0, 0, 32'h0);
        add(0, 32'h20, 1, 1, 1, 1, 1, 32'h2000_0004);
        // Clamping boundary: 0xFF is bin 7 directly, 0x100 and above clamp to bin 7.
        add(1, 32'h0000_1234, 1, 1, 1, 1, 1, 32'hE000_0001);
        add(0, 32'h0000_0100, 1, 1, 1, 1, 1, 32'hE000_0002);
        add(0, 32'h0000_00FF, 1, 1, 1, 1, 1, 32'hE000_0003);
        add(0, 32'h0000_00DF, 1, 1, 1, 1, 1, 32'hC000_0001);
        add(0, 32'h8000_0000, 1, 1, 1, 1, 1, 32'hE000_0004);
        add(0, 32'h0,         0, 1, 1, 0, 0, 32'h0);

        // Reset state, while held.
        #2;
        chk("rst_mvalid", {31'b0, m_tvalid}, 32'h0);
        chk("rst_mdata",  m_tdata, 32'h0);
        chk("rst_sready", {31'b0, s_tready}, 32'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("release_sready_pre_edge", {31'b0, s_tready}, 32'h0);
        @(posedge aclk);
        #1;
        chk("release_sready_post_edge", {31'b0, s_tready}, 32'h1);

        // Table-driven vectors.
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            s_tdata  = tbl[i].tdata;
            s_tvalid = tbl[i].tvalid;
            m_tready = tbl[i].mready;
            #1;
            chk($sformatf("vec%0d_sready", i), {31'b0, s_tready}, {31'b0, tbl[i].exp_sready});
            @(posedge aclk);
            #1;
            chk($sformatf("vec%0d_mvalid", i), {31'b0, m_tvalid}, {31'b0, tbl[i].exp_mvalid});
            if (tbl[i].chk_data) chk($sformatf("vec%0d_mdata", i), m_tdata, tbl[i].exp_mdata);
        end

        // Backpressure: one beat pending, downstream stalled, input keeps offering.
        do_reset();
        s_tdata  = 32'h10;
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        @(posedge aclk);
        #1;
        chk("bp_first_mdata", m_tdata, 32'h0000_0001);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall_sready", {31'b0, s_tready}, 32'h0);
            @(posedge aclk);
            #1;
            chk("bp_stall_mvalid", {31'b0, m_tvalid}, 32'h1);
            chk("bp_stall_mdata", m_tdata, 32'h0000_0001);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_sready", {31'b0, s_tready}, 32'h1);
        @(posedge aclk);
        #1;
        chk("bp_resume_mdata", m_tdata, 32'h0000_0002);
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        chk("bp_drain_mvalid", {31'b0, m_tvalid}, 32'h0);

        // Reset mid-stream, between edges.
        do_reset();
        s_tdata  = 32'h3F;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        chk("mid_pre_mdata", m_tdata, 32'h2000_0002);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_mvalid", {31'b0, m_tvalid}, 32'h0);
        chk("mid_rst_mdata", m_tdata, 32'h0);
        chk("mid_rst_sready", {31'b0, s_tready}, 32'h0);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        chk("mid_after_mdata", m_tdata, 32'h2000_0001);
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;

        // Saturation on the 3-bit-counter build.
        do_reset();
        s2_tdata  = 32'h0;
        s2_tvalid = 1'b1;
        m2_tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [31:0] e;
            e = (k < 7) ? 32'(k + 1) : 32'd7;
            #1;
            chk($sformatf("sat%0d_sready", k), {31'b0, s2_tready}, 32'h1);
            @(posedge aclk);
            #1;
            chk($sformatf("sat%0d_mdata", k), m2_tdata, e);
        end
        s2_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        chk("sat_drain_mvalid", {31'b0, m2_tvalid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
